// File: rtl/backprop_scheduler_pkg.sv
// Shared types for the backprop training sequencer: FSM state encoding and fault codes.
package backprop_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_DELTA,
    S_UPDATE,
    S_NEXT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_DP   = 2'd1;
  localparam logic [1:0] FAULT_WDOG = 2'd2;

  function automatic logic is_busy(input state_t s);
    return (s == S_FWD) || (s == S_DELTA) || (s == S_UPDATE) || (s == S_NEXT);
  endfunction

endpackage

// File: rtl/backprop_scheduler_if.sv
// Job strobes and completions exchanged between the scheduler and its datapath peers.
interface backprop_scheduler_if #(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int SAMPLE_ADDR_SIZE = 10
);
  logic                        fwd_start;
  logic                        fwd_done;
  logic [LAYER_ADDR_WIDTH-1:0] layer;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_index;
  logic                        delta_start;
  logic                        delta_valid;
  logic                        update_start;
  logic                        update_done;
  logic                        dp_error;

  modport master (
    output fwd_start, layer, sample_index, delta_start, update_start,
    input  fwd_done, delta_valid, update_done, dp_error
  );

  modport slave (
    input  fwd_start, layer, sample_index, delta_start, update_start,
    output fwd_done, delta_valid, update_done, dp_error
  );
endinterface

// File: rtl/backprop_scheduler_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting on a peer, flags when the count is all-ones.
module backprop_scheduler_watchdog #(
  parameter int TIMEOUT_WIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TIMEOUT_WIDTH-1:0] count_q;

  assign expired = (count_q == '1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + TIMEOUT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/backprop_scheduler.sv
// Training sequencer: forward pass, then delta/update jobs for layers LAYER_MAX..1, per sample and epoch.
module backprop_scheduler
  import backprop_scheduler_pkg::*;
#(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int LAYER_MAX        = 3,
  parameter int SAMPLE_ADDR_SIZE = 10,
  parameter int SAMPLE_NUM       = 1024,
  parameter int EPOCH_WIDTH      = 16,
  parameter int TIMEOUT_WIDTH    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [EPOCH_WIDTH-1:0] epochs,
  backprop_scheduler_if.master   bus,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [EPOCH_WIDTH-1:0] epoch_count
);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_TOP   = LAYER_ADDR_WIDTH'(LAYER_MAX);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ONE   = LAYER_ADDR_WIDTH'(1);
  localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_LAST = SAMPLE_ADDR_SIZE'(SAMPLE_NUM - 1);

  state_t                  state_q, state_d;
  logic                    fwd_q, fwd_d, delta_q, delta_d, update_q, update_d;
  logic [LAYER_ADDR_WIDTH-1:0] layer_q, layer_d;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_q, sample_d;
  logic [EPOCH_WIDTH-1:0]  epoch_q, epoch_d, epochs_lat_q, epochs_lat_d, epoch_inc;
  logic [1:0]              code_q, code_d;
  logic                    busy_q, done_q, fault_q;
  logic                    wd_expired;

  assign epoch_inc = epoch_q + EPOCH_WIDTH'(1);

  // Every entry into a wait state is accompanied by its strobe, so the strobes double as the clear.
  backprop_scheduler_watchdog #(.TIMEOUT_WIDTH(TIMEOUT_WIDTH)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (fwd_d || delta_d || update_d),
    .enable ((state_q == S_FWD) || (state_q == S_DELTA) || (state_q == S_UPDATE)),
    .expired(wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    fwd_d        = 1'b0;
    delta_d      = 1'b0;
    update_d     = 1'b0;
    layer_d      = layer_q;
    sample_d     = sample_q;
    epoch_d      = epoch_q;
    epochs_lat_d = epochs_lat_q;
    code_d       = code_q;

    if (is_busy(state_q) && abort) begin
      state_d = S_IDLE;
    end else if (is_busy(state_q) && bus.dp_error) begin
      state_d = S_FAULT;
      code_d  = FAULT_DP;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (abort) begin
            state_d = S_IDLE;
          end else if (start) begin
            sample_d     = '0;
            epoch_d      = '0;
            epochs_lat_d = epochs;
            if (epochs != '0) begin
              state_d = S_FWD;
              fwd_d   = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_FWD: begin
          if (bus.fwd_done) begin
            state_d = S_DELTA;
            layer_d = LAYER_TOP;
            delta_d = 1'b1;
          end else if (wd_expired) begin
            state_d = S_FAULT;
            code_d  = FAULT_WDOG;
          end
        end
        S_DELTA: begin
          // delta_valid seen while our own delta_start is out is left over from the previous job
          if (bus.delta_valid && !delta_q) begin
            state_d  = S_UPDATE;
            update_d = 1'b1;
          end else if (wd_expired) begin
            state_d = S_FAULT;
            code_d  = FAULT_WDOG;
          end
        end
        S_UPDATE: begin
          if (bus.update_done) begin
            if (layer_q == LAYER_ONE) begin
              state_d = S_NEXT;
            end else begin
              state_d = S_DELTA;
              layer_d = layer_q - LAYER_ONE;
              delta_d = 1'b1;
            end
          end else if (wd_expired) begin
            state_d = S_FAULT;
            code_d  = FAULT_WDOG;
          end
        end
        S_NEXT: begin
          if (sample_q == SAMPLE_LAST) begin
            sample_d = '0;
            epoch_d  = epoch_inc;
            if (epoch_inc == epochs_lat_q) begin
              state_d = S_DONE;
              layer_d = LAYER_TOP;
            end else begin
              state_d = S_FWD;
              fwd_d   = 1'b1;
            end
          end else begin
            sample_d = sample_q + SAMPLE_ADDR_SIZE'(1);
            state_d  = S_FWD;
            fwd_d    = 1'b1;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fwd_q        <= 1'b0;
      delta_q      <= 1'b0;
      update_q     <= 1'b0;
      layer_q      <= LAYER_TOP;
      sample_q     <= '0;
      epoch_q      <= '0;
      epochs_lat_q <= '0;
      code_q       <= FAULT_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fwd_q        <= fwd_d;
      delta_q      <= delta_d;
      update_q     <= update_d;
      layer_q      <= layer_d;
      sample_q     <= sample_d;
      epoch_q      <= epoch_d;
      epochs_lat_q <= epochs_lat_d;
      code_q       <= code_d;
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == S_DONE);
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign bus.fwd_start    = fwd_q;
  assign bus.delta_start  = delta_q;
  assign bus.update_start = update_q;
  assign bus.layer        = layer_q;
  assign bus.sample_index = sample_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign fault            = fault_q;
  assign fault_code       = code_q;
  assign epoch_count      = epoch_q;
endmodule
